// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: one shared prescaler tick drives N_CH independent
// channels, each OFF, steady ON, continuous BLINK or a counted BURST with a done pulse.
module led_blink_ctrl #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned HALF_W   = 8,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [HALF_W-1:0] cfg_half,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              tick,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   done
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_PREV = PRE_W'(TICK_DIV - 2);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  logic [PRE_W-1:0] pre_cnt;

  // Free-running prescaler; tick is registered so it is high while the count sits at its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
      tick    <= (pre_cnt == PRE_PREV);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mode_t             mode;
    logic [HALF_W-1:0] half;
    logic [HALF_W-1:0] phase;
    logic [CNT_W-1:0]  remaining;
    logic              led_q;
    logic              busy_q;
    logic              done_q;
    logic              hit;

    // Out-of-range channel numbers never match any generated index, so they are dropped here.
    assign hit = cfg_we && (cfg_ch == CH_W'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        mode      <= MODE_OFF;
        half      <= HALF_W'(1);
        phase     <= '0;
        remaining <= '0;
        led_q     <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (hit) begin
          half      <= (cfg_half == '0) ? HALF_W'(1) : cfg_half;
          remaining <= cfg_count;
          phase     <= '0;
          case (mode_t'(cfg_mode))
            MODE_OFF: begin
              mode   <= MODE_OFF;
              led_q  <= 1'b0;
              busy_q <= 1'b0;
            end
            MODE_ON: begin
              mode   <= MODE_ON;
              led_q  <= 1'b1;
              busy_q <= 1'b0;
            end
            MODE_BLINK: begin
              mode   <= MODE_BLINK;
              led_q  <= 1'b1;
              busy_q <= 1'b0;
            end
            MODE_BURST: begin
              if (cfg_count == '0) begin
                mode   <= MODE_OFF;
                led_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                mode   <= MODE_BURST;
                led_q  <= 1'b1;
                busy_q <= 1'b1;
              end
            end
          endcase
        end else if (tick && (mode == MODE_BLINK || mode == MODE_BURST)) begin
          if (phase == half - HALF_W'(1)) begin
            phase <= '0;
            led_q <= ~led_q;
            // A burst counts its pulses on the falling edge and ends on the last one.
            if (mode == MODE_BURST && led_q) begin
              remaining <= remaining - CNT_W'(1);
              if (remaining == CNT_W'(1)) begin
                mode   <= MODE_OFF;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end else begin
            phase <= phase + HALF_W'(1);
          end
        end
      end
    end

    assign led[i]  = led_q;
    assign busy[i] = busy_q;
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl with a fast prescaler (TICK_DIV=4).
module tb_led_blink_ctrl;

  localparam int unsigned N_CH     = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned HALF_W   = 8;
  localparam int unsigned CNT_W    = 8;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  typedef struct packed {
    logic [3:0] mask;
    logic [3:0] led;
    logic [3:0] busy;
    logic [3:0] done;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [1:0]        cfg_mode;
  logic [HALF_W-1:0] cfg_half;
  logic [CNT_W-1:0]  cfg_count;
  logic              tick;
  logic [N_CH-1:0]   led;
  logic [N_CH-1:0]   busy;
  logic [N_CH-1:0]   done;

  logic              cfg3_we;
  logic [1:0]        cfg3_ch;
  logic [1:0]        cfg3_mode;
  logic [HALF_W-1:0] cfg3_half;
  logic [CNT_W-1:0]  cfg3_count;
  logic              tick3;
  logic [2:0]        led3;
  logic [2:0]        busy3;
  logic [2:0]        done3;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  led_blink_ctrl #(
    .N_CH(N_CH), .TICK_DIV(TICK_DIV), .HALF_W(HALF_W), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_count(cfg_count), .tick(tick), .led(led), .busy(busy), .done(done)
  );

  led_blink_ctrl #(
    .N_CH(3), .TICK_DIV(TICK_DIV), .HALF_W(HALF_W), .CNT_W(CNT_W)
  ) u_dut3 (
    .clk(clk), .reset(reset), .cfg_we(cfg3_we), .cfg_ch(cfg3_ch), .cfg_mode(cfg3_mode),
    .cfg_half(cfg3_half), .cfg_count(cfg3_count), .tick(tick3), .led(led3), .busy(busy3), .done(done3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [1:0] mode,
                          input logic [HALF_W-1:0] half, input logic [CNT_W-1:0] count);
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_half  = half;
    cfg_count = count;
    cfg_we    = 1'b1;
    step();
    cfg_we    = 1'b0;
  endtask

  function automatic void push_exp(input logic [3:0] m, input logic [3:0] l,
                                   input logic [3:0] b, input logic [3:0] d);
    exp_t e;
    e.mask = m;
    e.led  = l;
    e.busy = b;
    e.done = d;
    sb.push_back(e);
  endfunction

  // Leaves the bench on a sample where tick is high, so the next edge is a tick edge.
  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 2 * TICK_DIV; i++) begin
      step();
      if (tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: tick=%b never rose within %0d cycles", tick, 2 * TICK_DIV);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    do_write(2'd0, M_BLINK, 8'd1, 8'd0);
    repeat (10) step();
    reset     = 1'b1;
    cfg_we    = 1'b1;
    cfg_ch    = 2'd1;
    cfg_mode  = M_ON;
    cfg_half  = 8'd1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({tick, led, busy, done, tick3, led3, busy3, done3} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d tick=%b led=%b busy=%b done=%b led3=%b required all 0",
                 k, tick, led, busy, done, led3);
      end
    end
    reset  = 1'b0;
    cfg_we = 1'b0;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (tick !== ((k % 4) == 3) || led !== 4'b0000) begin
        errors++;
        $display("FAIL reset_release cyc=%0d tick=%b led=%b required tick=%b led=0000",
                 k, tick, led, ((k % 4) == 3));
      end
      step();
    end
  endtask

  task automatic test_blink();
    exp_t e;
    int   k = 0;
    wait_tick();
    do_write(2'd1, M_BLINK, 8'd2, 8'd0);
    for (int i = 0; i < 80; i++)
      push_exp(4'b0010, ((i / 8) % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (({led, busy, done} & {3{e.mask}}) !== ({e.led, e.busy, e.done} & {3{e.mask}})) begin
        errors++;
        $display("FAIL blink_ch1 cyc=%0d led=%b busy=%b done=%b required led=%b busy=%b done=%b mask=%b",
                 k, led, busy, done, e.led, e.busy, e.done, e.mask);
      end
      if (sb.size() > 0) step();
      k++;
    end
  endtask

  task automatic test_burst();
    exp_t e;
    int   k = 0;
    wait_tick();
    do_write(2'd2, M_BURST, 8'd1, 8'd3);
    for (int i = 0; i < 28; i++)
      push_exp(4'b0100, (i < 20 && (i / 4) % 2 == 0) ? 4'b0100 : 4'b0000,
               (i < 20) ? 4'b0100 : 4'b0000, (i == 20) ? 4'b0100 : 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (({led, busy, done} & {3{e.mask}}) !== ({e.led, e.busy, e.done} & {3{e.mask}})) begin
        errors++;
        $display("FAIL burst_ch2 cyc=%0d led=%b busy=%b done=%b required led=%b busy=%b done=%b mask=%b",
                 k, led, busy, done, e.led, e.busy, e.done, e.mask);
      end
      if (sb.size() > 0) step();
      k++;
    end
  endtask

  task automatic test_burst_zero();
    exp_t e;
    int   k = 0;
    do_write(2'd3, M_BURST, 8'd5, 8'd0);
    push_exp(4'b1000, 4'b0000, 4'b0000, 4'b1000);
    push_exp(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (({led, busy, done} & {3{e.mask}}) !== ({e.led, e.busy, e.done} & {3{e.mask}})) begin
        errors++;
        $display("FAIL burst_zero_ch3 cyc=%0d led=%b busy=%b done=%b required led=%b busy=%b done=%b",
                 k, led, busy, done, e.led, e.busy, e.done);
      end
      if (sb.size() > 0) step();
      k++;
    end
  endtask

  // A zero half-period behaves as one tick; the burst is cut short by a write to ON.
  task automatic test_abort();
    exp_t e;
    int   k = 0;
    wait_tick();
    do_write(2'd2, M_BURST, 8'd0, 8'd5);
    for (int i = 0; i < 14; i++)
      push_exp(4'b0100, ((i / 4) % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0100, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (({led, busy, done} & {3{e.mask}}) !== ({e.led, e.busy, e.done} & {3{e.mask}})) begin
        errors++;
        $display("FAIL abort_pre cyc=%0d led=%b busy=%b done=%b required led=%b busy=%b done=%b",
                 k, led, busy, done, e.led, e.busy, e.done);
      end
      if (sb.size() > 0) step();
      k++;
    end
    do_write(2'd2, M_ON, 8'd1, 8'd0);
    for (int i = 0; i < 20; i++)
      push_exp(4'b0100, 4'b0100, 4'b0000, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (({led, busy, done} & {3{e.mask}}) !== ({e.led, e.busy, e.done} & {3{e.mask}})) begin
        errors++;
        $display("FAIL abort_post cyc=%0d led=%b busy=%b done=%b required led=%b busy=%b done=%b",
                 k, led, busy, done, e.led, e.busy, e.done);
      end
      if (sb.size() > 0) step();
      k++;
    end
  endtask

  task automatic test_isolation();
    exp_t       e;
    logic [3:0] el;
    int         k = 1;
    wait_tick();
    do_write(2'd0, M_BLINK, 8'd1, 8'd0);
    do_write(2'd1, M_BLINK, 8'd3, 8'd0);
    // Stray config without the strobe must leave channel 3 off.
    cfg_ch   = 2'd3;
    cfg_mode = M_ON;
    cfg_half = 8'd1;
    cfg_we   = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      el    = 4'b0100;
      el[0] = ((i / 4) % 2 == 0);
      el[1] = (i < 12) ? 1'b1 : (((i - 12) / 12) % 2 == 1);
      push_exp(4'b1111, el, 4'b0000, 4'b0000);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (({led, busy, done} & {3{e.mask}}) !== ({e.led, e.busy, e.done} & {3{e.mask}})) begin
        errors++;
        $display("FAIL isolation cyc=%0d led=%b busy=%b done=%b required led=%b busy=%b done=%b",
                 k, led, busy, done, e.led, e.busy, e.done);
      end
      if (sb.size() > 0) step();
      k++;
    end
  endtask

  task automatic test_n_ch3();
    cfg3_ch    = 2'd3;
    cfg3_mode  = M_ON;
    cfg3_half  = 8'd1;
    cfg3_count = 8'd0;
    cfg3_we    = 1'b1;
    step();
    cfg3_we = 1'b0;
    repeat (2) step();
    checks++;
    if (led3 !== 3'b000 || busy3 !== 3'b000 || done3 !== 3'b000) begin
      errors++;
      $display("FAIL nch3_out_of_range led3=%b busy3=%b done3=%b required all 000", led3, busy3, done3);
    end
    cfg3_ch = 2'd2;
    cfg3_we = 1'b1;
    step();
    cfg3_we = 1'b0;
    checks++;
    if (led3 !== 3'b100 || busy3 !== 3'b000) begin
      errors++;
      $display("FAIL nch3_in_range led3=%b busy3=%b required led3=100 busy3=000", led3, busy3);
    end
  endtask

  initial begin
    reset      = 1'b1;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_mode   = '0;
    cfg_half   = '0;
    cfg_count  = '0;
    cfg3_we    = 1'b0;
    cfg3_ch    = '0;
    cfg3_mode  = '0;
    cfg3_half  = '0;
    cfg3_count = '0;
    test_reset();
    test_blink();
    test_burst();
    test_burst_zero();
    test_abort();
    test_isolation();
    test_n_ch3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
